// File: rtl/facial_detection_core.sv
// Streaming two-rectangle Haar front end: o_feature/o_detect follow a window's bottom-right capture by 2 cycles.
// Pull source via o_pixel_request (no other backpressure); define FACE_DETECT_STATS_EN to add o_detect_count.
module facial_detection_core #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_WIDTH  = 32,
  parameter int FRAME_HEIGHT = 32,
  parameter int WIN          = 4,
  parameter int THRESHOLD    = 256,
  parameter int FRAME_GAP    = 4,
  parameter int FW           = DATA_WIDTH + 2*$clog2(WIN) + 1
) (
  input  logic                            clk_fpga,
  input  logic                            reset_fpga,
  input  logic [DATA_WIDTH-1:0]           pixel,
  output logic                            o_pixel_request,
  output logic                            o_detect,
  output logic [$clog2(FRAME_WIDTH)-1:0]  o_detect_x,
  output logic [$clog2(FRAME_HEIGHT)-1:0] o_detect_y,
  output logic signed [FW-1:0]            o_feature,
  output logic                            o_frame_done
`ifdef FACE_DETECT_STATS_EN
  ,
  output logic [15:0]                     o_detect_count
`endif
);
  localparam int XW   = $clog2(FRAME_WIDTH);
  localparam int YW   = $clog2(FRAME_HEIGHT);
  localparam int HW   = DATA_WIDTH + $clog2(WIN);
  localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int PW   = $clog2(NPIX);
  localparam int GW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] req_cnt;
  logic [GW-1:0] gap_cnt;
  logic          req_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          last_x, last_y, last_cap;

  logic [DATA_WIDTH-1:0] sr [WIN-1];
  logic [HW-1:0]         lb [WIN-1][FRAME_WIDTH];
  logic [HW-1:0]         hsum;
  logic [FW-1:0]         bot, top;
  logic signed [FW-1:0]  feat;
  logic                  win_vld, hit;

  logic                  vld_s1, hit_s1;
  logic signed [FW-1:0]  feat_s1;
  logic [XW-1:0]         x_s1;
  logic [YW-1:0]         y_s1;

  always_comb begin
    state_d         = state_q;
    o_pixel_request = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        o_pixel_request = 1'b1;
        if (req_cnt == PW'(NPIX-1)) state_d = GAP;
      end
      GAP:   if (gap_cnt == GW'(FRAME_GAP-1)) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Leaving FETCH is decided on the request count, so the last request never triggers an extra capture.
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q <= IDLE;
      req_cnt <= '0;
      gap_cnt <= '0;
      req_d   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_d   <= o_pixel_request;
      req_cnt <= (state_q == FETCH && state_d == FETCH) ? req_cnt + PW'(1) : '0;
      gap_cnt <= (state_q == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  assign last_x   = (x_q == XW'(FRAME_WIDTH-1));
  assign last_y   = (y_q == YW'(FRAME_HEIGHT-1));
  assign last_cap = req_d && last_x && last_y;

  always_comb begin
    hsum = HW'(pixel);
    if (x_q != '0) begin
      for (int i = 0; i < WIN-1; i++) hsum = hsum + HW'(sr[i]);
    end
    bot = FW'(hsum);
    top = '0;
    // lb[0] holds the previous row; the first WIN/2-1 buffers join the bottom half.
    for (int k = 0; k < WIN-1; k++) begin
      if (k < WIN/2-1) bot = bot + FW'(lb[k][x_q]);
      else             top = top + FW'(lb[k][x_q]);
    end
    feat    = bot - top;
    win_vld = req_d && (x_q >= XW'(WIN-1)) && (y_q >= YW'(WIN-1));
    hit     = (int'(feat) >= THRESHOLD);
  end

  always_ff @(posedge clk_fpga) begin
    if (req_d) begin
      lb[0][x_q] <= hsum;
      for (int k = 1; k < WIN-1; k++) lb[k][x_q] <= lb[k-1][x_q];
      sr[0] <= pixel;
      for (int i = 1; i < WIN-1; i++) sr[i] <= (x_q == '0) ? '0 : sr[i-1];
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      x_q          <= '0;
      y_q          <= '0;
      vld_s1       <= 1'b0;
      hit_s1       <= 1'b0;
      feat_s1      <= '0;
      x_s1         <= '0;
      y_s1         <= '0;
      o_detect     <= 1'b0;
      o_detect_x   <= '0;
      o_detect_y   <= '0;
      o_feature    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      if (req_d) begin
        x_q <= last_x ? '0 : x_q + XW'(1);
        if (last_x) y_q <= last_y ? '0 : y_q + YW'(1);
      end
      vld_s1 <= win_vld;
      hit_s1 <= win_vld && hit;
      if (win_vld) begin
        feat_s1 <= feat;
        x_s1    <= x_q;
        y_s1    <= y_q;
      end
      o_detect     <= hit_s1;
      o_frame_done <= last_cap;
      if (vld_s1) begin
        o_feature  <= feat_s1;
        o_detect_x <= x_s1;
        o_detect_y <= y_s1;
      end
    end
  end

`ifdef FACE_DETECT_STATS_EN
  // Counted at capture so the frame's final window is included when the total is latched.
  logic [15:0] det_cnt, det_cnt_inc;

  always_comb begin
    det_cnt_inc = det_cnt;
    if (win_vld && hit && det_cnt != 16'hFFFF) det_cnt_inc = det_cnt + 16'd1;
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      det_cnt        <= '0;
      o_detect_count <= '0;
    end else if (last_cap) begin
      o_detect_count <= det_cnt_inc;
      det_cnt        <= '0;
    end else begin
      det_cnt <= det_cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_facial_detection_core.sv
// Bench for facial_detection_core: table-driven window checks against hand values and a direct window-sum model.
module tb_facial_detection_core;
  localparam int DW = 12;
  localparam int FWID = 32;
  localparam int FHGT = 32;
  localparam int WIN = 4;
  localparam int FW = DW + 2*2 + 1;
  localparam int NV = 13;

  logic clk_fpga = 1'b0;
  logic reset_fpga = 1'b1;
  logic [DW-1:0] pixel = '0;
  logic req1, det1, fd1, req2, det2, fd2;
  logic [4:0] dx1, dy1, dx2, dy2;
  logic signed [FW-1:0] feat1, feat2;
`ifdef FACE_DETECT_STATS_EN
  logic [15:0] cnt1, cnt2;
`endif

  facial_detection_core #(.THRESHOLD(256)) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .pixel(pixel),
    .o_pixel_request(req1), .o_detect(det1), .o_detect_x(dx1), .o_detect_y(dy1),
    .o_feature(feat1), .o_frame_done(fd1)
`ifdef FACE_DETECT_STATS_EN
    , .o_detect_count(cnt1)
`endif
  );

  facial_detection_core #(.THRESHOLD(513)) dut_t513 (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .pixel(pixel),
    .o_pixel_request(req2), .o_detect(det2), .o_detect_x(dx2), .o_detect_y(dy2),
    .o_feature(feat2), .o_frame_done(fd2)
`ifdef FACE_DETECT_STATS_EN
    , .o_detect_count(cnt2)
`endif
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct { int mode; int x; int y; int feat; int det; int det2; } vec_t;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int src_mode = 0;
  int src_idx = 0;
  bit req_eff = 1'b0;

  int feat_map [FHGT][FWID];
  int feat2_map[FHGT][FWID];
  int det_map  [FHGT][FWID];
  int det2_map [FHGT][FWID];
  int cyc = 0, bx = 0, by = 0, req_idx = 0;
  bit [2:0] hist = '0;
  int det_pulses, det2_pulses, spurious, coord_err, fd_count, last_stats;
  int first_seen, first_x, first_y, first_cyc, req99_cyc;

  function automatic int pix_val(input int mode, input int n);
    case (mode)
      0:       return 100;
      1:       return n & 255;
      default: return 255 - (n & 255);
    endcase
  endfunction

  function automatic int model_feat(input int mode, input int x, input int y);
    int s = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        if (r < WIN/2) s += pix_val(mode, (y-r)*FWID + (x-c));
        else           s -= pix_val(mode, (y-r)*FWID + (x-c));
      end
    return s;
  endfunction

  // Source: updates pixel just after each edge at which it saw a request.
  initial forever begin
    @(posedge clk_fpga);
    #1;
    if (req_eff) begin
      pixel = DW'(pix_val(src_mode, src_idx));
      src_idx++;
    end
  end

  // Monitor: a request in cycle t is expected to produce its window result in cycle t+3.
  always @(negedge clk_fpga) begin
    bit slot, vld;
    cyc++;
    if (fd1 === 1'b1) begin
      fd_count++;
`ifdef FACE_DETECT_STATS_EN
      last_stats = int'(cnt1);
`endif
    end
    slot = hist[2];
    vld = slot && bx >= WIN-1 && by >= WIN-1;
    if (vld) begin
      feat_map[by][bx]  = int'(feat1);
      feat2_map[by][bx] = int'(feat2);
      det_map[by][bx]   = int'(det1);
      det2_map[by][bx]  = int'(det2);
      if (int'(dx1) != bx || int'(dy1) != by || int'(dx2) != bx || int'(dy2) != by) coord_err++;
      if (det1 === 1'b1 && first_seen == 0) begin
        first_seen = 1; first_x = bx; first_y = by; first_cyc = cyc;
      end
    end
    if (det1 === 1'b1) det_pulses++;
    if (det2 === 1'b1) det2_pulses++;
    if ((det1 === 1'b1 || det2 === 1'b1) && !vld) spurious++;
    if (slot) begin
      if (bx == FWID-1) begin bx = 0; by = (by == FHGT-1) ? 0 : by + 1; end
      else bx++;
    end
    req_eff = (req1 === 1'b1) && (reset_fpga !== 1'b1);
    if (req_eff) begin
      if (req_idx == 99) req99_cyc = cyc;
      req_idx++;
    end
    hist = {hist[1:0], req_eff};
    if (reset_fpga === 1'b1) begin
      hist = '0; bx = 0; by = 0; req_idx = 0;
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_maps();
    for (int y = 0; y < FHGT; y++)
      for (int x = 0; x < FWID; x++) begin
        feat_map[y][x] = -99999; feat2_map[y][x] = -99999;
        det_map[y][x] = -1; det2_map[y][x] = -1;
      end
    det_pulses = 0; det2_pulses = 0; spurious = 0; coord_err = 0; fd_count = 0;
    last_stats = -1; first_seen = 0; first_x = -1; first_y = -1; first_cyc = 0; req99_cyc = 0;
  endtask

  task automatic do_reset(input int mode);
    @(posedge clk_fpga);
    #2;
    reset_fpga = 1'b1;
    src_mode = mode;
    src_idx = 0;
    @(posedge clk_fpga);
    #1;
    chk("rst_request", req1, 0);
    chk("rst_detect", det1, 0);
    chk("rst_feature", feat1, 0);
    chk("rst_detect_x", dx1, 0);
    chk("rst_detect_y", dy1, 0);
    chk("rst_frame_done", fd1, 0);
`ifdef FACE_DETECT_STATS_EN
    chk("rst_detect_count", cnt1, 0);
`endif
    #1;
    reset_fpga = 1'b0;
    clear_maps();
  endtask

  task automatic run_until_fd(input int n);
    int t = 0;
    while (fd_count < n && t < 3000) begin
      @(negedge clk_fpga);
      t++;
    end
    chk("frame_done_timeout", (fd_count >= n) ? 1 : 0, 1);
    repeat (4) @(negedge clk_fpga);
  endtask

  task automatic check_run(input int mode, input int exp_fd);
    int mism = 0, nd1 = 0, nd2 = 0, f;
    for (int i = 0; i < NV; i++)
      if (vecs[i].mode == mode) begin
        chk($sformatf("m%0d_feat_%0d_%0d", mode, vecs[i].x, vecs[i].y), feat_map[vecs[i].y][vecs[i].x], vecs[i].feat);
        chk($sformatf("m%0d_det_%0d_%0d", mode, vecs[i].x, vecs[i].y), det_map[vecs[i].y][vecs[i].x], vecs[i].det);
        chk($sformatf("m%0d_feat513_%0d_%0d", mode, vecs[i].x, vecs[i].y), feat2_map[vecs[i].y][vecs[i].x], vecs[i].feat);
        chk($sformatf("m%0d_det513_%0d_%0d", mode, vecs[i].x, vecs[i].y), det2_map[vecs[i].y][vecs[i].x], vecs[i].det2);
      end
    for (int y = WIN-1; y < FHGT; y++)
      for (int x = WIN-1; x < FWID; x++) begin
        f = model_feat(mode, x, y);
        if (f >= 256) nd1++;
        if (f >= 513) nd2++;
        if (feat_map[y][x] != f || feat2_map[y][x] != f) mism++;
        if (det_map[y][x] != ((f >= 256) ? 1 : 0) || det2_map[y][x] != ((f >= 513) ? 1 : 0)) mism++;
      end
    chk($sformatf("m%0d_window_map", mode), mism, 0);
    chk($sformatf("m%0d_detect_pulses", mode), det_pulses, nd1);
    chk($sformatf("m%0d_detect_pulses_t513", mode), det2_pulses, nd2);
    chk($sformatf("m%0d_spurious_detect", mode), spurious, 0);
    chk($sformatf("m%0d_detect_coords", mode), coord_err, 0);
    chk($sformatf("m%0d_frame_done_count", mode), fd_count, exp_fd);
`ifdef FACE_DETECT_STATS_EN
    chk($sformatf("m%0d_detect_count_stat", mode), last_stats, nd1);
`endif
  endtask

  task automatic check_first_detect();
    chk("first_detect_x", first_x, 3);
    chk("first_detect_y", first_y, 3);
    chk("first_detect_latency", first_cyc - req99_cyc, 3);
  endtask

  initial begin
    int hi, lo, fd_at, t;
    vecs[0]  = '{1, 3, 3, 512, 1, 0};
    vecs[1]  = '{1, 31, 31, 512, 1, 0};
    vecs[2]  = '{1, 10, 5, 512, 1, 0};
    vecs[3]  = '{1, 17, 20, 512, 1, 0};
    vecs[4]  = '{1, 5, 8, -512, 0, 0};
    vecs[5]  = '{1, 5, 9, -1536, 0, 0};
    vecs[6]  = '{1, 5, 10, -512, 0, 0};
    vecs[7]  = '{2, 3, 3, -512, 0, 0};
    vecs[8]  = '{2, 5, 8, 512, 1, 0};
    vecs[9]  = '{2, 5, 9, 1536, 1, 1};
    vecs[10] = '{2, 31, 31, -512, 0, 0};
    vecs[11] = '{0, 3, 3, 0, 0, 0};
    vecs[12] = '{0, 31, 31, 0, 0, 0};

    // Handshake shape, then a second constant frame.
    do_reset(0);
    @(negedge clk_fpga);
    chk("request_idle_cycle", req1, 0);
    hi = 0;
    @(negedge clk_fpga);
    while (req1 === 1'b1 && hi < 2000) begin hi++; @(negedge clk_fpga); end
    chk("request_high_run", hi, 1024);
    lo = 0; fd_at = -1;
    while (req1 !== 1'b1 && lo < 50) begin
      lo++;
      if (fd1 === 1'b1 && fd_at < 0) fd_at = lo;
      @(negedge clk_fpga);
    end
    chk("request_low_run", lo, 4);
    chk("frame_done_position", fd_at, 2);
    run_until_fd(2);
    check_run(0, 2);

    do_reset(1);
    run_until_fd(1);
    check_run(1, 1);
    check_first_detect();

    do_reset(2);
    run_until_fd(1);
    check_run(2, 1);

    // Reset while pixel (10,5) is being fetched; the frame must restart cleanly.
    do_reset(1);
    t = 0;
    while (req_idx < 171 && t < 2000) begin @(negedge clk_fpga); t++; end
    chk("midframe_reached", (req_idx >= 171) ? 1 : 0, 1);
    do_reset(1);
    run_until_fd(1);
    check_run(1, 1);
    check_first_detect();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
